fetch_unit: RTL and testbench

Instruction-fetch stage sitting directly upstream of the control decoder. Holds the program counter, issues one word request at a time to instruction memory over a req/ack handshake, and presents the fetched word plus its `op`/`funct` fields to decode. Decode returns Branch/Zero/Jump/Jr and targets, from which the next PC is selected. No branch delay slot; at most one outstanding fetch.

---
 rtl/mips_pkg.sv | 18 +
 rtl/fetch_unit_if.sv | 33 +++
 rtl/fetch_npc.sv | 28 ++
 rtl/fetch_unit.sv | 79 +++++++
 tb/tb_fetch_unit.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode/funct constants, fetch FSM state type and default reset PC.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] FN_JR    = 6'd8;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StValid
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of instruction-memory handshake and decode-side signals for the fetch stage.
interface fetch_unit_if #(
  parameter int unsigned CNT_W = 32
);
  logic             imem_req;
  logic [31:0]      imem_addr;
  logic             imem_ack;
  logic [31:0]      imem_rdata;
  logic             instr_valid;
  logic [31:0]      instr;
  logic [5:0]       op;
  logic [5:0]       funct;
  logic [31:0]      pc_plus4;
  logic             instr_ready;
  logic             branch;
  logic             zero;
  logic [31:0]      branch_imm;
  logic             jump;
  logic             jr;
  logic [31:0]      jr_target;
  logic             misalign;
  logic [CNT_W-1:0] fetch_cnt;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, op, funct, pc_plus4, misalign, fetch_cnt,
    input  imem_ack, imem_rdata, instr_ready, branch, zero, branch_imm, jump, jr, jr_target
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, op, funct, pc_plus4, misalign, fetch_cnt,
    output imem_ack, imem_rdata, instr_ready, branch, zero, branch_imm, jump, jr, jr_target
  );
endinterface

// File: rtl/fetch_npc.sv
// Next-PC selection: JR > J/JAL > taken branch > sequential.
module fetch_npc (
  input  logic [31:0] i_pc_plus4,
  input  logic [25:0] i_instr_idx,
  input  logic        i_jr,
  input  logic [31:0] i_jr_target,
  input  logic        i_jump,
  input  logic        i_branch,
  input  logic        i_zero,
  input  logic [31:0] i_branch_imm,
  output logic [31:0] o_next_pc,
  output logic        o_misalign
);

  always_comb begin
    o_next_pc  = i_pc_plus4;
    o_misalign = 1'b0;
    if (i_jr) begin
      o_next_pc  = {i_jr_target[31:2], 2'b00};
      o_misalign = |i_jr_target[1:0];
    end else if (i_jump) begin
      o_next_pc = {i_pc_plus4[31:28], i_instr_idx, 2'b00};
    end else if (i_branch && i_zero) begin
      o_next_pc = i_pc_plus4 + (i_branch_imm << 2);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, single-outstanding imem request FSM, decode handoff.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned CNT_W    = 32
) (
  input logic          clk,
  input logic          rst_n,
  fetch_unit_if.master bus
);

  fetch_state_e     r_state, w_state_d;
  logic [31:0]      r_pc, r_instr, r_pc_plus4;
  logic [31:0]      w_next_pc;
  logic             r_misalign, w_misalign_set;
  logic [CNT_W-1:0] r_fetch_cnt;
  logic             w_capture, w_accept;

  assign w_capture = (r_state == StFetch) && bus.imem_ack;
  assign w_accept  = (r_state == StValid) && bus.instr_ready;

  fetch_npc u_npc (
    .i_pc_plus4   (r_pc_plus4),
    .i_instr_idx  (r_instr[25:0]),
    .i_jr         (bus.jr),
    .i_jr_target  (bus.jr_target),
    .i_jump       (bus.jump),
    .i_branch     (bus.branch),
    .i_zero       (bus.zero),
    .i_branch_imm (bus.branch_imm),
    .o_next_pc    (w_next_pc),
    .o_misalign   (w_misalign_set)
  );

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  w_state_d = StFetch;
      StFetch: if (bus.imem_ack) w_state_d = StValid;
      StValid: if (bus.instr_ready) w_state_d = StFetch;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_pc        <= RESET_PC;
      r_instr     <= 32'd0;
      r_pc_plus4  <= 32'd0;
      r_misalign  <= 1'b0;
      r_fetch_cnt <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_capture) begin
        r_instr    <= bus.imem_rdata;
        r_pc_plus4 <= r_pc + 32'd4;
      end
      if (w_accept) begin
        r_pc        <= w_next_pc;
        r_fetch_cnt <= r_fetch_cnt + CNT_W'(1);
        // Sticky until reset: a bad JR target is reported once and never forgotten.
        if (w_misalign_set) r_misalign <= 1'b1;
      end
    end
  end

  assign bus.imem_req    = (r_state == StFetch);
  assign bus.imem_addr   = r_pc;
  assign bus.instr_valid = (r_state == StValid);
  assign bus.instr       = r_instr;
  assign bus.op          = r_instr[31:26];
  assign bus.funct       = r_instr[5:0];
  assign bus.pc_plus4    = r_pc_plus4;
  assign bus.misalign    = r_misalign;
  assign bus.fetch_cnt   = r_fetch_cnt;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed fetch program with a memory responder and monitor.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if #(.CNT_W(2)) bus ();

  fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          lat;
    int          hold;
    logic        jr;
    logic [31:0] jt;
    logic        jump;
    logic        br;
    logic        z;
    logic [31:0] imm;
    logic [1:0]  cnt;
    logic        mis;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  cnt;
    logic        mis;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  task automatic add(input logic [31:0] addr, input logic [31:0] data, input int lat,
                     input int hold, input logic jr, input logic [31:0] jt, input logic jump,
                     input logic br, input logic z, input logic [31:0] imm,
                     input logic [1:0] cnt, input logic mis);
    vec_t v;
    v = '{addr: addr, data: data, lat: lat, hold: hold, jr: jr, jt: jt, jump: jump,
          br: br, z: z, imm: imm, cnt: cnt, mis: mis};
    vecs.push_back(v);
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.imem_req) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: address checked on the ack cycle, decode outputs on acceptance, hold during stall.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.imem_req && bus.imem_ack) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ack: got addr 0x%08h, expected no fetch", bus.imem_addr);
        end else begin
          chk("fetch_addr", bus.imem_addr, sb[0].addr);
        end
      end
      if (bus.instr_valid) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_valid: got instr 0x%08h, expected none", bus.instr);
        end else if (bus.instr_ready) begin
          exp_t e;
          e = sb.pop_front();
          chk("instr", bus.instr, e.data);
          chk("op", {26'd0, bus.op}, {26'd0, e.data[31:26]});
          chk("funct", {26'd0, bus.funct}, {26'd0, e.data[5:0]});
          chk("pc_plus4", bus.pc_plus4, e.addr + 32'd4);
          chk("fetch_cnt", {30'd0, bus.fetch_cnt}, {30'd0, e.cnt});
          chk("misalign", {31'd0, bus.misalign}, {31'd0, e.mis});
        end else begin
          chk("stall_req", {31'd0, bus.imem_req}, 32'd0);
          chk("stall_instr", bus.instr, sb[0].data);
        end
      end
    end
  end

  initial begin
    bit ok;
    bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.instr_ready = 1'b0;
    bus.branch = 1'b0; bus.zero = 1'b0; bus.branch_imm = '0;
    bus.jump = 1'b0; bus.jr = 1'b0; bus.jr_target = '0;

    //   addr          data          lat hold jr jt            j  br z  imm           cnt mis
    add(32'h0000_0000, 32'h2008_0005, 2, 0, 0, 32'h0,         0, 0, 0, 32'h0,         0, 0);
    add(32'h0000_0004, 32'h0000_0000, 0, 0, 0, 32'h0,         0, 0, 0, 32'h0,         1, 0);
    add(32'h0000_0008, 32'h1000_FFFE, 1, 0, 0, 32'h0,         0, 1, 1, 32'hFFFF_FFFE, 2, 0);
    add(32'h0000_0004, 32'h0000_0000, 0, 1, 0, 32'h0,         0, 0, 0, 32'h0,         3, 0);
    add(32'h0000_0008, 32'h1000_FFFE, 3, 0, 0, 32'h0,         0, 1, 0, 32'hFFFF_FFFE, 0, 0);
    add(32'h0000_000C, 32'h0000_0000, 0, 0, 0, 32'h0,         0, 0, 0, 32'h0,         1, 0);
    add(32'h0000_0010, 32'h0800_0010, 1, 0, 0, 32'h0,         1, 0, 0, 32'h0,         2, 0);
    add(32'h0000_0040, 32'h03E0_0008, 0, 5, 1, 32'h0000_0102, 1, 1, 1, 32'h10,        3, 0);
    add(32'h0000_0100, 32'h0800_0100, 2, 0, 0, 32'h0,         1, 1, 1, 32'h10,        0, 1);
    add(32'h0000_0400, 32'hAC00_0000, 0, 0, 0, 32'h0,         0, 0, 0, 32'h0,         1, 1);
    add(32'h0000_0404, 32'h0060_0008, 1, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 32'h0,         2, 1);
    add(32'hFFFF_FFFC, 32'h0000_0000, 0, 0, 0, 32'h0,         0, 0, 0, 32'h0,         3, 1);
    add(32'h0000_0000, 32'h2008_0005, 0, 0, 0, 32'h0,         0, 0, 0, 32'h0,         0, 1);

    repeat (3) begin
      @(negedge clk);
      chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
      chk("rst_addr", bus.imem_addr, 32'd0);
      chk("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
      chk("rst_instr", bus.instr, 32'd0);
      chk("rst_pc_plus4", bus.pc_plus4, 32'd0);
      chk("rst_misalign_cnt", {29'd0, bus.misalign, bus.fetch_cnt}, 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("first_req", {31'd0, bus.imem_req}, 32'd1);
    chk("first_addr", bus.imem_addr, 32'd0);

    foreach (vecs[k]) begin
      exp_t e;
      wait_req(ok);
      if (!ok) begin
        checks++; errors++;
        $display("FAIL req_timeout: got imem_req=0, expected request for vector %0d", k);
        break;
      end
      repeat (vecs[k].lat) begin
        @(posedge clk);
        #1;
      end
      e = '{addr: vecs[k].addr, data: vecs[k].data, cnt: vecs[k].cnt, mis: vecs[k].mis};
      sb.push_back(e);
      bus.imem_ack = 1'b1;
      bus.imem_rdata = vecs[k].data;
      @(posedge clk);
      #1;
      bus.imem_ack = 1'b0;
      bus.imem_rdata = '0;
      repeat (vecs[k].hold) begin
        @(posedge clk);
        #1;
      end
      bus.jr = vecs[k].jr; bus.jr_target = vecs[k].jt; bus.jump = vecs[k].jump;
      bus.branch = vecs[k].br; bus.zero = vecs[k].z; bus.branch_imm = vecs[k].imm;
      bus.instr_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.instr_ready = 1'b0;
      bus.jr = 1'b0; bus.jr_target = '0; bus.jump = 1'b0;
      bus.branch = 1'b0; bus.zero = 1'b0; bus.branch_imm = '0;
    end
    chk("sb_drained", sb.size(), 32'd0);

    wait_req(ok);
    chk("last_next_addr", bus.imem_addr, 32'h0000_0004);
    chk("last_cnt", {30'd0, bus.fetch_cnt}, 32'd1);

    // Reset lands in the middle of the ack cycle.
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("midrst_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("midrst_instr", bus.instr, 32'd0);
    chk("midrst_misalign_cnt", {29'd0, bus.misalign, bus.fetch_cnt}, 32'd0);
    chk("midrst_addr", bus.imem_addr, 32'd0);
    @(posedge clk);
    #1;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = '0;
    chk("rst_hold_valid", {31'd0, bus.instr_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("restart_req", {31'd0, bus.imem_req}, 32'd1);
    chk("restart_addr", bus.imem_addr, 32'd0);
    chk("restart_instr", bus.instr, 32'd0);
    chk("restart_valid", {31'd0, bus.instr_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
